// File: rtl/sat_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_arb_pkg : shared types and constants for sat_add_arbiter         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package sat_arb_pkg;

  localparam int NREQ      = 4;
  localparam int SAT_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sat_add_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_add_arbiter_if : request/response bus of the saturating adder    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface sat_add_arbiter_if
  import sat_arb_pkg::*;
#(
  parameter int N    = 8,
  parameter int NREQ = sat_arb_pkg::NREQ
);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [N-1:0]      rsp_sum;
  logic              rsp_sat;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_sat
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_sat
  );

endinterface
`default_nettype wire

// File: rtl/sat_add.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_add : combinational signed add, clamped to the N-bit range       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sat_add #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         sat
);

  localparam logic [N-1:0] C_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] C_MIN = {1'b1, {(N-1){1'b0}}};

  logic [N:0] w_full;

  assign w_full = {a[N-1], a} + {b[N-1], b};

  // Overflow shows as the two top bits of the widened sum disagreeing.
  always_comb begin
    sum = w_full[N-1:0];
    sat = 1'b0;
    if (w_full[N] != w_full[N-1]) begin
      sat = 1'b1;
      sum = w_full[N] ? C_MIN : C_MAX;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sat_add_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_add_arbiter : round-robin arbiter feeding one saturating adder   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sat_add_arbiter
  import sat_arb_pkg::*;
#(
  parameter int N    = 8,
  parameter int NREQ = sat_arb_pkg::NREQ
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sat_add_arbiter_if.slave     bus,
  input  logic                 sat_clr,
  output logic [SAT_CNT_W-1:0] sat_count
);

  localparam logic [SAT_CNT_W-1:0] C_SAT_MAX = '1;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [1:0]             r_last;
  logic [1:0]             w_win;
  logic                   w_any;
  logic                   w_grant;
  logic [N-1:0]           r_a;
  logic [N-1:0]           r_b;
  logic [N-1:0]           w_sum;
  logic                   w_sat;
  logic [N-1:0]           r_rsp_sum;
  logic                   r_rsp_sat;
  logic [1:0]             r_rsp_id;
  logic [SAT_CNT_W-1:0]   r_sat_count;
  logic [SAT_CNT_W-1:0]   w_sat_count_nxt;
  logic                   w_sat_inc;

  // Search order starts just after the last winner; the last winner is tried last.
  always_comb begin : p_arb
    logic [1:0] idx;
    idx   = '0;
    w_any = 1'b0;
    w_win = r_last;
    for (int k = 1; k <= NREQ; k++) begin
      idx = r_last + 2'(k);
      if (!w_any && bus.req_valid[idx]) begin
        w_any = 1'b1;
        w_win = idx;
      end
    end
  end

  assign w_grant       = (r_state == IDLE) && w_any;
  assign bus.req_ready = (w_grant && rst_n) ? ({{(NREQ-1){1'b0}}, 1'b1} << w_win) : '0;

  always_comb begin : p_fsm
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_any) w_state_nxt = CALC;
      CALC:    w_state_nxt = RESP;
      RESP:    if (bus.rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  sat_add #(.N(N)) u_sat_add (
    .a   (r_a),
    .b   (r_b),
    .sum (w_sum),
    .sat (w_sat)
  );

  assign w_sat_inc       = bus.rsp_valid && bus.rsp_ready && r_rsp_sat && (r_sat_count != C_SAT_MAX);
  assign w_sat_count_nxt = sat_clr   ? '0 :
                           w_sat_inc ? r_sat_count + SAT_CNT_W'(1) : r_sat_count;

  // r_last doubles as the owner index of the in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_last      <= 2'd3;
      r_a         <= '0;
      r_b         <= '0;
      r_rsp_sum   <= '0;
      r_rsp_sat   <= 1'b0;
      r_rsp_id    <= '0;
      r_sat_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sat_count <= w_sat_count_nxt;
      if (w_grant) begin
        r_last <= w_win;
        r_a    <= bus.req_a[w_win*N +: N];
        r_b    <= bus.req_b[w_win*N +: N];
      end
      if (r_state == CALC) begin
        r_rsp_sum <= w_sum;
        r_rsp_sat <= w_sat;
        r_rsp_id  <= r_last;
      end
    end
  end

  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_sum   = r_rsp_sum;
  assign bus.rsp_sat   = r_rsp_sat;
  assign bus.rsp_id    = r_rsp_id;
  assign sat_count     = r_sat_count;

endmodule
`default_nettype wire

// File: tb/tb_sat_add_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sat_add_arbiter : directed self-checking bench for sat_add_arbiter|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_sat_add_arbiter;

  logic        clk;
  logic        rst_n;
  logic        sat_clr;
  logic [15:0] sat_count;
  int          checks;
  int          errors;

  sat_add_arbiter_if #(.N(8), .NREQ(4)) bus ();

  sat_add_arbiter #(.N(8), .NREQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .sat_clr   (sat_clr),
    .sat_count (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Entered and left at posedge+1 with the DUT idle.
  task automatic do_op(input logic [3:0] v, input logic [31:0] a, input logic [31:0] b,
                       input bit hold, input bit clr,
                       output logic [3:0] gnt, output logic [1:0] id, output logic [7:0] sum,
                       output logic sat, output int lat);
    bus.req_valid = v;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.rsp_ready = 1'b0;
    #1 gnt = bus.req_ready;
    @(posedge clk); #1;
    if (!hold) bus.req_valid = '0;
    lat = 1;
    while (!bus.rsp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    id  = bus.rsp_id;
    sum = bus.rsp_sum;
    sat = bus.rsp_sat;
    bus.rsp_ready = 1'b1;
    sat_clr       = clr;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    sat_clr       = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 4'b1111;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
    checks++; if ({bus.rsp_id, bus.rsp_sum, bus.rsp_sat} !== 11'd0) begin errors++; $display("FAIL reset_rsp_fields: got id=%0d sum=%h sat=%b expected zeros", bus.rsp_id, bus.rsp_sum, bus.rsp_sat); end
    checks++; if (sat_count !== 16'd0) begin errors++; $display("FAIL reset_sat_count: got %h expected 0000", sat_count); end
    bus.req_valid = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [3:0] gnt; logic [1:0] id; logic [7:0] sum; logic sat; int lat;
    do_op(4'b0001, 32'd100, 32'd27, 1'b0, 1'b0, gnt, id, sum, sat, lat);
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL basic_grant: got %b expected 0001", gnt); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL basic_latency: got %0d expected 2", lat); end
    checks++; if (sum !== 8'd127) begin errors++; $display("FAIL basic_sum: got %h expected 7f", sum); end
    checks++; if (sat !== 1'b0) begin errors++; $display("FAIL basic_sat: got %b expected 0", sat); end
    checks++; if (id !== 2'd0) begin errors++; $display("FAIL basic_id: got %0d expected 0", id); end
    checks++; if (sat_count !== 16'd0) begin errors++; $display("FAIL basic_sat_count: got %h expected 0000", sat_count); end
  endtask

  task automatic test_saturate();
    logic [3:0] gnt; logic [1:0] id; logic [7:0] sum; logic sat; int lat;
    // -5 + 3 on requester 2: exact negative result, no clamp.
    do_op(4'b0100, 32'h00FB_0000, 32'h0003_0000, 1'b0, 1'b0, gnt, id, sum, sat, lat);
    checks++; if ({id, sum, sat} !== {2'd2, 8'hFE, 1'b0}) begin errors++; $display("FAIL neg_exact: got id=%0d sum=%h sat=%b expected id=2 sum=fe sat=0", id, sum, sat); end
    do_op(4'b0001, 32'd100, 32'd100, 1'b0, 1'b0, gnt, id, sum, sat, lat);
    checks++; if ({sum, sat} !== {8'h7F, 1'b1}) begin errors++; $display("FAIL pos_clamp: got sum=%h sat=%b expected sum=7f sat=1", sum, sat); end
    do_op(4'b0001, 32'h0000_009C, 32'h0000_009C, 1'b0, 1'b0, gnt, id, sum, sat, lat);
    checks++; if ({sum, sat} !== {8'h80, 1'b1}) begin errors++; $display("FAIL neg_clamp: got sum=%h sat=%b expected sum=80 sat=1", sum, sat); end
    checks++; if (sat_count !== 16'd2) begin errors++; $display("FAIL sat_count_two: got %h expected 0002", sat_count); end
  endtask

  task automatic test_round_robin();
    logic [3:0] gnt; logic [1:0] id; logic [7:0] sum; logic sat; int lat;
    pulse_reset();
    for (int k = 0; k < 8; k++) begin
      do_op(4'b1111, {8'd40, 8'd30, 8'd20, 8'd10}, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b1, 1'b0, gnt, id, sum, sat, lat);
      checks++; if (gnt !== (4'b0001 << (k % 4))) begin errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, gnt, 4'b0001 << (k % 4)); end
      checks++; if (id !== 2'(k % 4)) begin errors++; $display("FAIL rr_id[%0d]: got %0d expected %0d", k, id, k % 4); end
      checks++; if (sum !== 8'(11 * (k % 4 + 1))) begin errors++; $display("FAIL rr_sum[%0d]: got %0d expected %0d", k, sum, 11 * (k % 4 + 1)); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL rr_latency[%0d]: got %0d expected 2", k, lat); end
    end
    bus.req_valid = '0;
  endtask

  task automatic test_backpressure();
    bus.req_valid = 4'b0010;
    bus.req_a     = {8'd0, 8'd0, 8'd120, 8'd0};
    bus.req_b     = {8'd0, 8'd0, 8'd50, 8'd0};
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant: got %b expected 0010", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid = 4'b1101;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_sat, bus.req_ready} !== {1'b1, 2'd1, 8'h7F, 1'b1, 4'b0000}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid=%b id=%0d sum=%h sat=%b ready=%b expected valid=1 id=1 sum=7f sat=1 ready=0000",
                 c, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_sat, bus.req_ready);
      end
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    #1;
    checks++; if ({bus.rsp_valid, bus.req_ready} !== {1'b1, 4'b0000}) begin errors++; $display("FAIL bp_accept_cycle: got valid=%b ready=%b expected valid=1 ready=0000", bus.rsp_valid, bus.req_ready); end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    checks++; if ({bus.rsp_valid, bus.req_ready} !== {1'b0, 4'b0100}) begin errors++; $display("FAIL bp_next_grant: got valid=%b ready=%b expected valid=0 ready=0100", bus.rsp_valid, bus.req_ready); end
    checks++; if (sat_count !== 16'd1) begin errors++; $display("FAIL bp_sat_count: got %h expected 0001", sat_count); end
    // Withdrawn before the edge: nothing granted, pointer stays on requester 1.
    bus.req_valid = '0;
    @(posedge clk); #1;
    bus.req_valid = 4'b1101;
    #1;
    checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL bp_pointer_kept: got %b expected 0100", bus.req_ready); end
    bus.req_valid = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [3:0] gnt; logic [1:0] id; logic [7:0] sum; logic sat; int lat;
    bit seen;
    bus.req_valid = 4'b1000;
    bus.req_a     = {8'd1, 24'd0};
    bus.req_b     = {8'd1, 24'd0};
    @(posedge clk); #1;
    bus.req_valid = '0;
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.rsp_valid, bus.req_ready} !== 5'b0) begin errors++; $display("FAIL midrst_handshake: got valid=%b ready=%b expected 0/0000", bus.rsp_valid, bus.req_ready); end
    checks++; if ({bus.rsp_id, bus.rsp_sum, bus.rsp_sat} !== 11'd0) begin errors++; $display("FAIL midrst_rsp_fields: got id=%0d sum=%h sat=%b expected zeros", bus.rsp_id, bus.rsp_sum, bus.rsp_sat); end
    checks++; if (sat_count !== 16'd0) begin errors++; $display("FAIL midrst_sat_count: got %h expected 0000", sat_count); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (bus.rsp_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_response: got rsp_valid seen=%b expected 0", seen); end
    do_op(4'b1111, 32'd5, 32'd6, 1'b0, 1'b0, gnt, id, sum, sat, lat);
    checks++; if ({gnt, id, sum} !== {4'b0001, 2'd0, 8'd11}) begin errors++; $display("FAIL midrst_first_grant: got gnt=%b id=%0d sum=%0d expected gnt=0001 id=0 sum=11", gnt, id, sum); end
  endtask

  task automatic test_sat_count();
    logic [3:0] gnt; logic [1:0] id; logic [7:0] sum; logic sat; int lat;
    force dut.w_sat_count_nxt = 16'hFFFE;
    @(posedge clk); #1;
    release dut.w_sat_count_nxt;
    #1;
    checks++; if (sat_count !== 16'hFFFE) begin errors++; $display("FAIL cnt_preload: got %h expected fffe", sat_count); end
    do_op(4'b0001, 32'd100, 32'd100, 1'b0, 1'b0, gnt, id, sum, sat, lat);
    checks++; if (sat_count !== 16'hFFFF) begin errors++; $display("FAIL cnt_reach_max: got %h expected ffff", sat_count); end
    do_op(4'b0001, 32'd100, 32'd100, 1'b0, 1'b0, gnt, id, sum, sat, lat);
    checks++; if (sat_count !== 16'hFFFF) begin errors++; $display("FAIL cnt_hold_max: got %h expected ffff", sat_count); end
    do_op(4'b0001, 32'h0000_0080, 32'h0000_0080, 1'b0, 1'b1, gnt, id, sum, sat, lat);
    checks++; if ({sum, sat} !== {8'h80, 1'b1}) begin errors++; $display("FAIL cnt_min_min: got sum=%h sat=%b expected sum=80 sat=1", sum, sat); end
    checks++; if (sat_count !== 16'h0000) begin errors++; $display("FAIL cnt_clear_priority: got %h expected 0000", sat_count); end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    sat_clr       = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_basic();
    test_saturate();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_sat_count();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
